// File: rtl/i2c_txn_controller.sv
// ---------------------------------------------------------------------------
// i2c_txn_controller
//
// Purpose: host-side transaction sequencer for a byte-oriented I2C master.
// It accepts one command at a time and hands it to the master. Write bytes go
// from a host write FIFO to the master on each data request. Bytes the master
// reads are collected into a host read FIFO. The end of every transaction is
// reported with a one-cycle done pulse.
//
// Optional feature: define I2C_TXN_TIMEOUT_EN to build a watchdog on the
// LAUNCH phase. Without it, LAUNCH waits indefinitely and timeout is 0.
//
// Parameters:
//   FIFO_DEPTH      entries in each of the write and read FIFOs (pow2, >= 8)
//   TIMEOUT_CYCLES  launch watchdog limit in clk cycles
//
// Ports:
//   clk, rst                 system clock, async active-high reset
//   cmd_*                    host command (valid/ready, rnw, addr, len)
//   wr_valid/wr_ready/wr_data   host write-byte stream into the write FIFO
//   rd_valid/rd_ready/rd_data   host read-byte stream out of the read FIFO
//   done/short_rd            end-of-transaction pulse, short-read flag
//   rd_ovf                   sticky read-FIFO overflow, cleared on cmd accept
//   timeout                  watchdog expiry pulse
//   m_*                      master-facing control and data handshake
// ---------------------------------------------------------------------------
`default_nettype none

module i2c_txn_controller #(
  parameter int FIFO_DEPTH     = 8,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_rnw,
  input  logic [6:0] cmd_addr,
  input  logic [2:0] cmd_len,
  input  logic       wr_valid,
  output logic       wr_ready,
  input  logic [7:0] wr_data,
  output logic       rd_valid,
  input  logic       rd_ready,
  output logic [7:0] rd_data,
  output logic       done,
  output logic       short_rd,
  output logic       rd_ovf,
  output logic       timeout,
  output logic       m_start,
  input  logic       m_ready,
  input  logic       m_busy,
  input  logic       m_data_request,
  output logic       m_data_valid,
  input  logic       m_data_available,
  output logic       m_read_nwrite,
  output logic [6:0] m_addr,
  output logic [7:0] m_data_i,
  input  logic [7:0] m_data_o,
  output logic [2:0] m_data_size
);

  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, LAUNCH, RUN, FINISH} state_t;

  state_t     state;
  state_t     state_next;

  logic       accept;
  logic       timeout_hit;
  logic       req_q;
  logic       avail_q;
  logic       req_rise;
  logic       avail_rise;
  logic       data_pend;
  logic [2:0] byte_cnt;

  // m_busy only matters to a watchdog that looks at it; this one counts
  // LAUNCH cycles alone, so the input is sunk here.
  logic       unused_busy;
  assign unused_busy = m_busy;

  // ---------------- write FIFO ----------------
  logic [7:0]  wf_mem [FIFO_DEPTH];
  logic [AW:0] wf_wptr;
  logic [AW:0] wf_rptr;
  logic        wf_empty;
  logic        wf_full;
  logic        wf_push;
  logic        wf_pop;

  assign wf_empty = (wf_wptr == wf_rptr);
  assign wf_full  = (wf_wptr[AW] != wf_rptr[AW]) &&
                    (wf_wptr[AW-1:0] == wf_rptr[AW-1:0]);
  assign wr_ready = ~wf_full;
  assign wf_push  = wr_valid & wr_ready;
  // A byte is only pulled once the master has asked for one; an empty FIFO
  // simply leaves the request pending and the master stalls.
  assign wf_pop   = data_pend & ~wf_empty & (state == RUN);

  // ---------------- read FIFO ----------------
  logic [7:0]  rf_mem [FIFO_DEPTH];
  logic [AW:0] rf_wptr;
  logic [AW:0] rf_rptr;
  logic        rf_empty;
  logic        rf_full;
  logic        rf_push_req;
  logic        rf_push;
  logic        rf_pop;
  logic        rf_drop;

  assign rf_empty    = (rf_wptr == rf_rptr);
  assign rf_full     = (rf_wptr[AW] != rf_rptr[AW]) &&
                       (rf_wptr[AW-1:0] == rf_rptr[AW-1:0]);
  assign rd_valid    = ~rf_empty;
  assign rd_data     = rf_mem[rf_rptr[AW-1:0]];
  assign rf_pop      = rd_valid & rd_ready;
  assign rf_push_req = avail_rise & m_read_nwrite & (state == RUN);
  // A pop in the same cycle frees the head slot, so a full FIFO still takes it.
  assign rf_push     = rf_push_req & (~rf_full | rf_pop);
  assign rf_drop     = rf_push_req & rf_full & ~rf_pop;

  assign req_rise   = m_data_request & ~req_q;
  assign avail_rise = m_data_available & ~avail_q;
  assign accept     = cmd_valid & cmd_ready;

  // FIFO storage carries no reset; emptiness is defined by the pointers.
  always_ff @(posedge clk) begin
    if (wf_push) wf_mem[wf_wptr[AW-1:0]] <= wr_data;
    if (rf_push) rf_mem[rf_wptr[AW-1:0]] <= m_data_o;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wf_wptr <= '0;
      wf_rptr <= '0;
      rf_wptr <= '0;
      rf_rptr <= '0;
    end else begin
      if (wf_push) wf_wptr <= wf_wptr + 1'b1;
      if (wf_pop)  wf_rptr <= wf_rptr + 1'b1;
      if (rf_push) rf_wptr <= rf_wptr + 1'b1;
      if (rf_pop)  rf_rptr <= rf_rptr + 1'b1;
    end
  end

  // ---------------- launch watchdog ----------------
`ifdef I2C_TXN_TIMEOUT_EN
  localparam int WDW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT_CYCLES - 1);

  logic [WDW-1:0] wd_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd_cnt <= '0;
    end else if (accept) begin
      wd_cnt <= '0;
    end else if (state == LAUNCH) begin
      wd_cnt <= wd_cnt + 1'b1;
    end
  end

  // Fires on the TIMEOUT_CYCLES-th LAUNCH cycle if the master is still ready.
  assign timeout_hit = (state == LAUNCH) && m_ready && (wd_cnt == WD_LAST);
`else
  assign timeout_hit = 1'b0;
`endif
  assign timeout = timeout_hit;

  // ---------------- control FSM ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    cmd_ready  = 1'b0;
    m_start    = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) state_next = LAUNCH;
      end
      LAUNCH: begin
        m_start = 1'b1;
        if (!m_ready)        state_next = RUN;
        else if (timeout_hit) state_next = IDLE;
      end
      RUN: begin
        if (m_ready) state_next = FINISH;
      end
      FINISH: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // A read that delivered fewer bytes than asked for was NACKed or aborted.
  assign short_rd = done & m_read_nwrite & (byte_cnt < m_data_size);

  // ---------------- command latch, data handshake, status ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_addr        <= '0;
      m_read_nwrite <= 1'b0;
      m_data_size   <= '0;
      byte_cnt      <= '0;
      req_q         <= 1'b0;
      avail_q       <= 1'b0;
      data_pend     <= 1'b0;
      m_data_valid  <= 1'b0;
      m_data_i      <= '0;
      rd_ovf        <= 1'b0;
    end else begin
      req_q   <= m_data_request;
      avail_q <= m_data_available;

      if (accept) begin
        m_addr        <= cmd_addr;
        m_read_nwrite <= cmd_rnw;
        m_data_size   <= cmd_len;
        byte_cnt      <= '0;
        rd_ovf        <= 1'b0;
      end else begin
        if (rf_drop) rd_ovf <= 1'b1;
        // Counts bytes the master delivered, dropped ones included.
        if (rf_push_req && byte_cnt != 3'd7) byte_cnt <= byte_cnt + 3'd1;
      end

      // The request edge always withdraws the previous byte first, so the
      // master never mistakes stale data for the byte it just asked for.
      if (state == FINISH) begin
        m_data_valid <= 1'b0;
        data_pend    <= 1'b0;
      end else if (req_rise && !m_read_nwrite && state == RUN) begin
        m_data_valid <= 1'b0;
        data_pend    <= 1'b1;
      end else if (wf_pop) begin
        m_data_i     <= wf_mem[wf_rptr[AW-1:0]];
        m_data_valid <= 1'b1;
        data_pend    <= 1'b0;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_i2c_txn_controller.sv
// ---------------------------------------------------------------------------
// tb_i2c_txn_controller
//
// Self-checking bench for i2c_txn_controller. Stimulus tasks play the host
// and a simple I2C master model, and queue the bytes and done flags they
// expect. A monitor pops those queues whenever the DUT presents a write byte,
// a read byte or a done pulse.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_i2c_txn_controller;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid, cmd_ready, cmd_rnw;
  logic [6:0] cmd_addr;
  logic [2:0] cmd_len;
  logic       wr_valid, wr_ready;
  logic [7:0] wr_data;
  logic       rd_valid, rd_ready;
  logic [7:0] rd_data;
  logic       done, short_rd, rd_ovf, timeout;
  logic       m_start, m_ready, m_busy, m_data_request, m_data_valid;
  logic       m_data_available, m_read_nwrite;
  logic [6:0] m_addr;
  logic [7:0] m_data_i, m_data_o;
  logic [2:0] m_data_size;

  int errors = 0;
  int checks = 0;

  logic [7:0] exp_wdata[$];
  logic [7:0] exp_rdata[$];
  logic       exp_short[$];
  logic       mdv_q = 1'b0;
  logic       expect_timeout = 1'b0;

  always #5 clk = ~clk;

  i2c_txn_controller #(.FIFO_DEPTH(8), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rnw(cmd_rnw),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
    .done(done), .short_rd(short_rd), .rd_ovf(rd_ovf), .timeout(timeout),
    .m_start(m_start), .m_ready(m_ready), .m_busy(m_busy),
    .m_data_request(m_data_request), .m_data_valid(m_data_valid),
    .m_data_available(m_data_available), .m_read_nwrite(m_read_nwrite),
    .m_addr(m_addr), .m_data_i(m_data_i), .m_data_o(m_data_o),
    .m_data_size(m_data_size)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Inputs change 1 ns after the rising edge, well away from it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: sampled on the falling edge, between input changes and DUT edges.
  always @(negedge clk) begin
    if (rst) begin
      mdv_q = 1'b0;
    end else begin
      if (m_data_valid && !mdv_q) begin
        if (exp_wdata.size() == 0) checkOutput("unexpected_m_data_valid", 1, 0);
        else checkOutput("m_data_i", m_data_i, exp_wdata.pop_front());
      end
      mdv_q = m_data_valid;
      if (rd_valid && rd_ready) begin
        if (exp_rdata.size() == 0) checkOutput("unexpected_rd_valid", 1, 0);
        else checkOutput("rd_data", rd_data, exp_rdata.pop_front());
      end
      if (done) begin
        if (exp_short.size() == 0) checkOutput("unexpected_done", 1, 0);
        else checkOutput("short_rd", short_rd, exp_short.pop_front());
      end
      if (timeout && !expect_timeout) checkOutput("unexpected_timeout", 1, 0);
    end
  end

  // Hard stop in case something wedges despite the bounded waits.
  initial begin
    #500000;
    $display("[TB] FAIL global_time_limit: got hang, expected completion");
    $fatal(1, "[TB] time limit");
  end

  task automatic applyStimulus(input logic rnw, input logic [6:0] addr,
                               input logic [2:0] len);
    int n = 0;
    while (!cmd_ready && n < 100) begin step(); n++; end
    if (n == 100) checkOutput("cmd_ready_wait", 0, 1);
    cmd_valid = 1'b1; cmd_rnw = rnw; cmd_addr = addr; cmd_len = len;
    step();
    cmd_valid = 1'b0;
    checkOutput("m_addr", m_addr, addr);
    checkOutput("m_read_nwrite", m_read_nwrite, rnw);
    checkOutput("m_data_size", m_data_size, len);
    checkOutput("m_start_launch", m_start, 1);
    checkOutput("rd_ovf_clear_on_accept", rd_ovf, 0);
  endtask

  task automatic pushWrite(input logic [7:0] b);
    int n = 0;
    while (!wr_ready && n < 100) begin step(); n++; end
    if (n == 100) checkOutput("wr_ready_wait", 0, 1);
    wr_valid = 1'b1; wr_data = b;
    step();
    wr_valid = 1'b0;
  endtask

  task automatic masterLaunch();
    m_ready = 1'b0;
    step();
    checkOutput("m_start_dropped", m_start, 0);
  endtask

  task automatic masterRequest();
    int n = 0;
    m_data_request = 1'b1;
    step();
    while (!m_data_valid && n < 200) begin step(); n++; end
    if (n == 200) checkOutput("m_data_valid_wait", 0, 1);
    m_data_request = 1'b0;
    step();
  endtask

  task automatic masterAvail(input logic [7:0] b);
    m_data_o = b; m_data_available = 1'b1;
    step();
    m_data_available = 1'b0;
    step();
  endtask

  task automatic masterFinish();
    m_ready = 1'b1;
    step();
    step();
  endtask

  initial begin
    logic [7:0] wvec [3];
    logic [7:0] rvec [4];
    int         first_to;
    logic       saw;

    wvec[0] = 8'hA5; wvec[1] = 8'h5A; wvec[2] = 8'h3C;
    rvec[0] = 8'h11; rvec[1] = 8'h22; rvec[2] = 8'h33; rvec[3] = 8'h44;

    rst = 1'b1; cmd_valid = 0; cmd_rnw = 0; cmd_addr = 0; cmd_len = 0;
    wr_valid = 0; wr_data = 0; rd_ready = 0;
    m_ready = 1; m_busy = 0; m_data_request = 0; m_data_available = 0; m_data_o = 0;
    step(); step();
    rst = 1'b0;
    step();

    // Reset state
    checkOutput("rst_cmd_ready", cmd_ready, 1);
    checkOutput("rst_m_start", m_start, 0);
    checkOutput("rst_m_data_valid", m_data_valid, 0);
    checkOutput("rst_rd_valid", rd_valid, 0);
    checkOutput("rst_wr_ready", wr_ready, 1);
    checkOutput("rst_rd_ovf", rd_ovf, 0);
    checkOutput("rst_m_addr", m_addr, 0);

    // Three-byte write to 0x50
    for (int i = 0; i < 3; i++) begin pushWrite(wvec[i]); exp_wdata.push_back(wvec[i]); end
    exp_short.push_back(1'b0);
    applyStimulus(1'b0, 7'h50, 3'd3);
    masterLaunch();
    for (int i = 0; i < 3; i++) masterRequest();
    masterFinish();

    // Four-byte read, full length delivered
    rd_ready = 1'b1;
    exp_short.push_back(1'b0);
    applyStimulus(1'b1, 7'h21, 3'd4);
    masterLaunch();
    for (int i = 0; i < 4; i++) begin exp_rdata.push_back(rvec[i]); masterAvail(rvec[i]); end
    masterFinish();

    // Five-byte read NACKed after two bytes
    exp_short.push_back(1'b1);
    applyStimulus(1'b1, 7'h22, 3'd5);
    masterLaunch();
    exp_rdata.push_back(8'hAB); masterAvail(8'hAB);
    exp_rdata.push_back(8'hCD); masterAvail(8'hCD);
    masterFinish();
    step(); step();

    // Address-only probes, read and write
    exp_short.push_back(1'b0);
    applyStimulus(1'b1, 7'h30, 3'd0);
    masterLaunch(); masterFinish();
    exp_short.push_back(1'b0);
    applyStimulus(1'b0, 7'h31, 3'd0);
    masterLaunch(); masterFinish();

    // Write with the FIFO empty at the request edge
    exp_short.push_back(1'b0);
    applyStimulus(1'b0, 7'h3A, 3'd2);
    masterLaunch();
    m_data_request = 1'b1;
    saw = 1'b0;
    for (int i = 0; i < 100; i++) begin step(); if (m_data_valid || timeout) saw = 1'b1; end
    checkOutput("stall_no_valid_no_timeout", saw, 0);
    exp_wdata.push_back(8'h77);
    wr_valid = 1'b1; wr_data = 8'h77;
    step();
    wr_valid = 1'b0;
    checkOutput("mdv_at_push", m_data_valid, 0);
    step();
    checkOutput("mdv_cycle_after_push", m_data_valid, 1);
    m_data_request = 1'b0;
    step();
    exp_wdata.push_back(8'h88);
    pushWrite(8'h88);
    masterRequest();
    masterFinish();

    // Read FIFO overflow across two un-drained reads
    rd_ready = 1'b0;
    exp_short.push_back(1'b0);
    applyStimulus(1'b1, 7'h40, 3'd7);
    masterLaunch();
    for (int i = 1; i <= 7; i++) begin exp_rdata.push_back(8'(i)); masterAvail(8'(i)); end
    masterFinish();
    checkOutput("rd_ovf_at_seven", rd_ovf, 0);
    exp_short.push_back(1'b0);
    applyStimulus(1'b1, 7'h41, 3'd7);
    masterLaunch();
    exp_rdata.push_back(8'h08);
    for (int i = 8; i <= 14; i++) masterAvail(8'(i));
    masterFinish();
    checkOutput("rd_ovf_set", rd_ovf, 1);
    step(); step();
    checkOutput("rd_ovf_sticky", rd_ovf, 1);
    rd_ready = 1'b1;
    for (int i = 0; i < 10; i++) step();
    checkOutput("rd_drained", rd_valid, 0);
    exp_short.push_back(1'b0);
    applyStimulus(1'b0, 7'h42, 3'd0);
    masterLaunch(); masterFinish();

    // Launch watchdog
`ifdef I2C_TXN_TIMEOUT_EN
    expect_timeout = 1'b1;
    applyStimulus(1'b1, 7'h11, 3'd1);
    first_to = 0;
    for (int i = 1; i <= 20; i++) begin
      if (timeout && first_to == 0) first_to = i;
      step();
    end
    expect_timeout = 1'b0;
    checkOutput("timeout_cycle", first_to, 16);
    checkOutput("timeout_cmd_ready", cmd_ready, 1);
    checkOutput("timeout_m_start", m_start, 0);
`else
    applyStimulus(1'b1, 7'h11, 3'd1);
    first_to = 0;
    for (int i = 1; i <= 40; i++) begin
      if (timeout) first_to = i;
      step();
    end
    checkOutput("no_timeout_logic", first_to, 0);
    checkOutput("launch_waits_m_start", m_start, 1);
    checkOutput("launch_waits_cmd_ready", cmd_ready, 0);
    exp_short.push_back(1'b1);
    masterLaunch(); masterFinish();
`endif

    // Reset in the middle of a read
    for (int i = 0; i < 8; i++) pushWrite(8'hE0 + 8'(i));
    checkOutput("wr_fifo_full", wr_ready, 0);
    rd_ready = 1'b0;
    applyStimulus(1'b1, 7'h2B, 3'd3);
    masterLaunch();
    masterAvail(8'h99);
    checkOutput("pre_rst_rd_valid", rd_valid, 1);
    rst = 1'b1;
    m_ready = 1'b1;
    #1;
    checkOutput("mid_rst_m_start", m_start, 0);
    checkOutput("mid_rst_m_data_valid", m_data_valid, 0);
    checkOutput("mid_rst_m_data_i", m_data_i, 0);
    checkOutput("mid_rst_m_addr", m_addr, 0);
    checkOutput("mid_rst_m_read_nwrite", m_read_nwrite, 0);
    checkOutput("mid_rst_m_data_size", m_data_size, 0);
    checkOutput("mid_rst_done", done, 0);
    checkOutput("mid_rst_short_rd", short_rd, 0);
    checkOutput("mid_rst_rd_ovf", rd_ovf, 0);
    checkOutput("mid_rst_timeout", timeout, 0);
    checkOutput("mid_rst_rd_valid", rd_valid, 0);
    checkOutput("mid_rst_wr_ready", wr_ready, 1);
    step();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) step();
    checkOutput("post_rst_cmd_ready", cmd_ready, 1);

    checkOutput("exp_wdata_left", exp_wdata.size(), 0);
    checkOutput("exp_rdata_left", exp_rdata.size(), 0);
    checkOutput("exp_done_left", exp_short.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
